// File: rtl/sys_pkg.sv
// Shared definitions for the command-frame controller: command byte codes and FSM states.
package sys_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StOpa,
    StOpb,
    StFun,
    StAluWait,
    StPush
  } state_e;

endpackage

// File: rtl/sys_ctrl_timeout.sv
// Mid-frame inactivity counter: clears on request, counts while enabled and
// raises a one-cycle expiry when TIMEOUT_CYC consecutive counting cycles have elapsed.
module sys_ctrl_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;

  assign o_expire = i_inc & ~i_clr & (r_cnt == LastCnt);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr || o_expire) begin
      w_cnt_nxt = '0;
    end else if (i_inc) begin
      w_cnt_nxt = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/sys_ctrl_frame.sv
// Command-frame controller: decodes UART RX frames into RF writes/reads and ALU
// operations, and streams RF read data or ALU results into the TX FIFO.
module sys_ctrl_frame
  import sys_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned RES_BYTES   = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned OPA_ADDR    = 0
) (
  input  logic                            REF_CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           RX_P_Data,
  input  logic                            RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]           RdData,
  input  logic                            RdData_Valid,
  output logic [DATA_WIDTH-1:0]           WrData,
  output logic [ADDR_WIDTH-1:0]           Address,
  output logic                            Wr_En,
  output logic                            Rd_En,
  input  logic [RES_BYTES*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                            OUT_Valid,
  output logic                            ALU_EN,
  output logic [ADDR_WIDTH-1:0]           ALU_FUN,
  output logic                            Gate_EN,
  input  logic                            Fifo_Full,
  output logic                            WR_INC,
  output logic [DATA_WIDTH-1:0]           Fifo_Wr_Data,
  output logic                            clk_div_en,
  output logic                            Frame_Err
);

  localparam int unsigned ResW = RES_BYTES * DATA_WIDTH;
  localparam int unsigned CntW = $clog2(RES_BYTES + 1);
  localparam logic [DATA_WIDTH-1:0] CmdWr  = DATA_WIDTH'(CMD_RF_WR);
  localparam logic [DATA_WIDTH-1:0] CmdRd  = DATA_WIDTH'(CMD_RF_RD);
  localparam logic [DATA_WIDTH-1:0] CmdOp  = DATA_WIDTH'(CMD_ALU_OP);
  localparam logic [DATA_WIDTH-1:0] CmdNop = DATA_WIDTH'(CMD_ALU_NOP);
  localparam logic [ADDR_WIDTH-1:0] OpaAddr = ADDR_WIDTH'(OPA_ADDR);
  localparam logic [ADDR_WIDTH-1:0] OpbAddr = ADDR_WIDTH'(OPA_ADDR + 1);
  localparam logic [CntW-1:0] AluLast = CntW'(RES_BYTES - 1);

  state_e                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_wr_data, w_wr_data;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
  logic [ADDR_WIDTH-1:0]   r_alu_fun, w_alu_fun;
  logic [DATA_WIDTH-1:0]   r_fifo_data, w_fifo_data;
  logic                    r_wr_en, w_wr_en;
  logic                    r_rd_en, w_rd_en;
  logic                    r_alu_en, w_alu_en;
  logic                    r_gate_en, w_gate_en;
  logic                    r_wr_inc, w_wr_inc;
  logic                    r_frame_err, w_frame_err;
  logic [ResW-1:0]         r_res, w_res;
  logic [CntW-1:0]         r_idx, w_idx;
  logic [CntW-1:0]         r_last, w_last;
  logic                    w_timed;
  logic                    w_to_clr;
  logic                    w_expire;

  // Only states that are waiting on the next RX byte are subject to the timeout.
  assign w_timed = r_state inside {StWrAddr, StWrData, StRdAddr, StOpa, StOpb, StFun};
  assign w_to_clr = RX_D_VLD | (r_state == StIdle);

  sys_ctrl_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (REF_CLK),
    .rst_n   (RST),
    .i_clr   (w_to_clr),
    .i_inc   (w_timed),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wr_data   = r_wr_data;
    w_addr      = r_addr;
    w_alu_fun   = r_alu_fun;
    w_fifo_data = r_fifo_data;
    w_gate_en   = r_gate_en;
    w_res       = r_res;
    w_idx       = r_idx;
    w_last      = r_last;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_alu_en    = 1'b0;
    w_wr_inc    = 1'b0;
    w_frame_err = 1'b0;

    case (r_state)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_Data == CmdWr) begin
            w_state_nxt = StWrAddr;
          end else if (RX_P_Data == CmdRd) begin
            w_state_nxt = StRdAddr;
          end else if (RX_P_Data == CmdOp) begin
            w_state_nxt = StOpa;
          end else if (RX_P_Data == CmdNop) begin
            w_state_nxt = StFun;
          end else begin
            w_frame_err = 1'b1;
          end
        end
      end
      StWrAddr: begin
        if (RX_D_VLD) begin
          w_addr      = RX_P_Data[ADDR_WIDTH-1:0];
          w_state_nxt = StWrData;
        end
      end
      StWrData: begin
        if (RX_D_VLD) begin
          w_wr_data   = RX_P_Data;
          w_wr_en     = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StRdAddr: begin
        if (RX_D_VLD) begin
          w_addr      = RX_P_Data[ADDR_WIDTH-1:0];
          w_rd_en     = 1'b1;
          w_state_nxt = StRdWait;
        end
      end
      StRdWait: begin
        if (RdData_Valid) begin
          w_res       = ResW'(RdData);
          w_idx       = '0;
          w_last      = '0;
          w_state_nxt = StPush;
        end
      end
      StOpa: begin
        if (RX_D_VLD) begin
          w_addr      = OpaAddr;
          w_wr_data   = RX_P_Data;
          w_wr_en     = 1'b1;
          w_state_nxt = StOpb;
        end
      end
      StOpb: begin
        if (RX_D_VLD) begin
          w_addr      = OpbAddr;
          w_wr_data   = RX_P_Data;
          w_wr_en     = 1'b1;
          w_state_nxt = StFun;
        end
      end
      StFun: begin
        if (RX_D_VLD) begin
          w_alu_fun   = RX_P_Data[ADDR_WIDTH-1:0];
          w_alu_en    = 1'b1;
          w_gate_en   = 1'b1;
          w_state_nxt = StAluWait;
        end
      end
      StAluWait: begin
        if (OUT_Valid) begin
          w_res       = ALU_OUT;
          w_gate_en   = 1'b0;
          w_idx       = '0;
          w_last      = AluLast;
          w_state_nxt = StPush;
        end
      end
      StPush: begin
        // A word leaves the shift register only in a cycle where it is actually pushed.
        if (!Fifo_Full) begin
          w_wr_inc    = 1'b1;
          w_fifo_data = r_res[DATA_WIDTH-1:0];
          w_res       = r_res >> DATA_WIDTH;
          if (r_idx == r_last) begin
            w_state_nxt = StIdle;
          end else begin
            w_idx = r_idx + CntW'(1);
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Expiry only fires in byte-waiting states with no byte this cycle, so it never
    // overlaps an accepted byte or an illegal-command error.
    if (w_expire) begin
      w_state_nxt = StIdle;
      w_frame_err = 1'b1;
      w_gate_en   = 1'b0;
    end
  end

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= StIdle;
      r_wr_data   <= '0;
      r_addr      <= '0;
      r_alu_fun   <= '0;
      r_fifo_data <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_alu_en    <= 1'b0;
      r_gate_en   <= 1'b0;
      r_wr_inc    <= 1'b0;
      r_frame_err <= 1'b0;
      r_res       <= '0;
      r_idx       <= '0;
      r_last      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_data   <= w_wr_data;
      r_addr      <= w_addr;
      r_alu_fun   <= w_alu_fun;
      r_fifo_data <= w_fifo_data;
      r_wr_en     <= w_wr_en;
      r_rd_en     <= w_rd_en;
      r_alu_en    <= w_alu_en;
      r_gate_en   <= w_gate_en;
      r_wr_inc    <= w_wr_inc;
      r_frame_err <= w_frame_err;
      r_res       <= w_res;
      r_idx       <= w_idx;
      r_last      <= w_last;
    end
  end

  assign WrData       = r_wr_data;
  assign Address      = r_addr;
  assign Wr_En        = r_wr_en;
  assign Rd_En        = r_rd_en;
  assign ALU_EN       = r_alu_en;
  assign ALU_FUN      = r_alu_fun;
  assign Gate_EN      = r_gate_en;
  assign WR_INC       = r_wr_inc;
  assign Fifo_Wr_Data = r_fifo_data;
  assign Frame_Err    = r_frame_err;
  assign clk_div_en   = 1'b1;

endmodule
